// File: rtl/seq_pkg.sv
// ============================================================================
//  seq_pkg
//  Shared constants for the microstore next-state sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [2:0] {
    NS_DECODE = 3'b000,
    NS_FETCH  = 3'b001,
    NS_JUMP   = 3'b010,
    NS_INC    = 3'b011,
    NS_CBR    = 3'b100,
    NS_CWAIT  = 3'b101,
    NS_CDEC   = 3'b110,
    NS_HALT   = 3'b111
  } ns_ctrl_e;

  localparam logic [1:0] COND_MOC   = 2'd0;
  localparam logic [1:0] COND_BR    = 2'd1;
  localparam logic [1:0] COND_TRAP  = 2'd2;
  localparam logic [1:0] COND_ANNUL = 2'd3;

  localparam logic [7:0] DEFAULT_RESET_STATE = 8'd0;
  localparam logic [7:0] DEFAULT_FETCH_STATE = 8'd1;
  localparam logic [7:0] DEFAULT_TRAP_STATE  = 8'd240;

endpackage

`default_nettype wire

// File: rtl/cond_mux.sv
// ============================================================================
//  cond_mux
//  Selects one condition source and applies the microinstruction inversion.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module cond_mux
  import seq_pkg::*;
(
  input  logic       inv,
  input  logic [1:0] cond_sel,
  input  logic [3:0] cond_in,
  output logic       cond_out
);

  logic selected;

  always_comb begin
    selected = 1'b0;
    unique case (cond_sel)
      COND_MOC:   selected = cond_in[COND_MOC];
      COND_BR:    selected = cond_in[COND_BR];
      COND_TRAP:  selected = cond_in[COND_TRAP];
      COND_ANNUL: selected = cond_in[COND_ANNUL];
      default:    selected = 1'b0;
    endcase
  end

  assign cond_out = selected ^ inv;

endmodule

`default_nettype wire

// File: rtl/microstore_sequencer.sv
// ============================================================================
//  microstore_sequencer
//  Next microstore address sequencer; optional CWAIT watchdog via SEQ_TIMEOUT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module microstore_sequencer
  import seq_pkg::*;
#(
  parameter int               ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_STATE = ADDR_W'(DEFAULT_RESET_STATE),
  parameter logic [ADDR_W-1:0] FETCH_STATE = ADDR_W'(DEFAULT_FETCH_STATE),
  parameter logic [ADDR_W-1:0] TRAP_STATE  = ADDR_W'(DEFAULT_TRAP_STATE),
  parameter int               TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        n_ctrl,
  input  logic              inv,
  input  logic [1:0]        cond_sel,
  input  logic [3:0]        cond_in,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] enc_addr,
  output logic [ADDR_W-1:0] state,
  output logic              cond_out,
  output logic              stall,
  output logic              timeout
);

  logic              c;
  logic [ADDR_W-1:0] state_inc;
  logic [ADDR_W-1:0] next_state;

  cond_mux u_cond_mux (
    .inv      (inv),
    .cond_sel (cond_sel),
    .cond_in  (cond_in),
    .cond_out (c)
  );

  assign cond_out  = c;
  assign state_inc = state + ADDR_W'(1);
  assign stall     = (ns_ctrl_e'(n_ctrl) == NS_CWAIT) && !c;

  always_comb begin
    next_state = state;
    unique case (ns_ctrl_e'(n_ctrl))
      NS_DECODE: next_state = enc_addr;
      NS_FETCH:  next_state = FETCH_STATE;
      NS_JUMP:   next_state = cr_addr;
      NS_INC:    next_state = state_inc;
      NS_CBR:    next_state = c ? cr_addr : state_inc;
      NS_CWAIT:  next_state = c ? state_inc : state;
      NS_CDEC:   next_state = c ? enc_addr : state_inc;
      NS_HALT:   next_state = state;
      default:   next_state = state;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_fire;

  // Fires on the edge that would complete TIMEOUT_CYC consecutive stalls;
  // a condition arriving on that edge clears stall and so wins.
  assign wd_fire = stall && (wd_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RESET_STATE;
      timeout <= 1'b0;
      wd_cnt  <= 8'd0;
    end else if (wd_fire) begin
      state   <= TRAP_STATE;
      timeout <= 1'b1;
      wd_cnt  <= 8'd0;
    end else begin
      state   <= next_state;
      timeout <= 1'b0;
      wd_cnt  <= stall ? wd_cnt + 8'd1 : 8'd0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{TRAP_STATE, 32'(TIMEOUT_CYC)};
  assign timeout    = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end
`endif

endmodule

`default_nettype wire
